// File: rtl/hermes_traffic_node.sv
`default_nettype none
// ============================================================================
// hermes_traffic_node : Hermes local-port packet injector plus checking sink
// Rev 1.0
// ============================================================================
module hermes_traffic_node #(
    parameter int FLIT_SIZE = 32,
    parameter int SRC_X     = 0,
    parameter int SRC_Y     = 0,
    parameter int TS_WIDTH  = 32,
    parameter int SEQ_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [TS_WIDTH-1:0]    cmd_time_i,
    input  logic [FLIT_SIZE/4-1:0] cmd_tgt_x_i,
    input  logic [FLIT_SIZE/4-1:0] cmd_tgt_y_i,
    input  logic [FLIT_SIZE-1:0]   cmd_size_i,
    output logic                   tx_o,
    output logic [FLIT_SIZE-1:0]   data_o,
    input  logic                   credit_i,
    input  logic                   rx_i,
    input  logic [FLIT_SIZE-1:0]   data_i,
    output logic                   credit_o,
    output logic                   rpt_valid_o,
    input  logic                   rpt_ready_i,
    output logic [FLIT_SIZE/2-1:0] rpt_src_o,
    output logic [FLIT_SIZE-1:0]   rpt_size_o,
    output logic [SEQ_WIDTH-1:0]   rpt_seq_o,
    output logic [TS_WIDTH-1:0]    rpt_latency_o,
    output logic [1:0]             rpt_err_o
);

    localparam int                   QW    = FLIT_SIZE / 4;
    localparam logic [QW-1:0]        MY_X  = QW'(SRC_X);
    localparam logic [QW-1:0]        MY_Y  = QW'(SRC_Y);
    localparam logic [FLIT_SIZE-1:0] TWO   = FLIT_SIZE'(2);
    localparam logic [FLIT_SIZE-1:0] THREE = FLIT_SIZE'(3);

    typedef enum logic [2:0] {I_IDLE, I_WAIT, I_HDR, I_SIZE, I_TS, I_SEQ, I_BODY} inj_state_t;
    typedef enum logic [2:0] {R_HDR, R_SIZE, R_TS, R_SEQ, R_BODY} snk_state_t;

    inj_state_t             inj_state, inj_next;
    snk_state_t             snk_state, snk_next;
    logic [TS_WIDTH-1:0]    timer, cmd_time, ts_cap, time_diff;
    logic [QW-1:0]          tgt_x, tgt_y;
    logic [FLIT_SIZE-1:0]   pkt_size, body_cnt;
    logic [SEQ_WIDTH-1:0]   seq_cnt;

    logic [FLIT_SIZE/2-1:0] rx_src;
    logic [FLIT_SIZE-1:0]   rx_size, rx_len, rx_cnt;
    logic [TS_WIDTH-1:0]    rx_lat;
    logic [SEQ_WIDTH-1:0]   rx_seq;
    logic                   rx_bad_tgt, rx_bad_pay, rx_xfer, body_bad, rpt_load;

    assign time_diff = timer - cmd_time;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) timer <= '0;
        else         timer <= timer + TS_WIDTH'(1);
    end

    // ---------------------------------------------------------------- injector
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inj_state <= I_IDLE;
            cmd_time  <= '0;
            tgt_x     <= '0;
            tgt_y     <= '0;
            pkt_size  <= '0;
            body_cnt  <= '0;
            ts_cap    <= '0;
            seq_cnt   <= '0;
        end else begin
            inj_state <= inj_next;
            if (inj_state == I_IDLE && cmd_valid_i) begin
                cmd_time <= cmd_time_i;
                tgt_x    <= cmd_tgt_x_i;
                tgt_y    <= cmd_tgt_y_i;
                pkt_size <= (cmd_size_i < TWO) ? TWO : cmd_size_i;
            end
            // Timestamp equals the timer value seen while TS is first presented,
            // so an unstalled loopback measures zero latency.
            if (inj_state == I_SIZE && credit_i)
                ts_cap <= timer + TS_WIDTH'(1);
            if (inj_state == I_SEQ && credit_i) begin
                seq_cnt  <= seq_cnt + SEQ_WIDTH'(1);
                body_cnt <= '0;
            end
            if (inj_state == I_BODY && credit_i)
                body_cnt <= body_cnt + FLIT_SIZE'(1);
        end
    end

    always_comb begin
        inj_next    = inj_state;
        cmd_ready_o = 1'b0;
        tx_o        = 1'b0;
        data_o      = '0;
        case (inj_state)
            I_IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_valid_i) inj_next = I_WAIT;
            end
            I_WAIT: if (!time_diff[TS_WIDTH-1]) inj_next = I_HDR;
            I_HDR: begin
                tx_o   = 1'b1;
                data_o = {MY_X, MY_Y, tgt_x, tgt_y};
                if (credit_i) inj_next = I_SIZE;
            end
            I_SIZE: begin
                tx_o   = 1'b1;
                data_o = pkt_size;
                if (credit_i) inj_next = I_TS;
            end
            I_TS: begin
                tx_o   = 1'b1;
                data_o = FLIT_SIZE'(ts_cap);
                if (credit_i) inj_next = I_SEQ;
            end
            I_SEQ: begin
                tx_o   = 1'b1;
                data_o = FLIT_SIZE'(seq_cnt);
                if (credit_i) inj_next = (pkt_size == TWO) ? I_IDLE : I_BODY;
            end
            I_BODY: begin
                tx_o   = 1'b1;
                data_o = body_cnt;
                if (credit_i && body_cnt == pkt_size - THREE) inj_next = I_IDLE;
            end
            default: inj_next = I_IDLE;
        endcase
    end

    // -------------------------------------------------------------------- sink
    assign credit_o = !(rpt_valid_o && !rpt_ready_i);
    assign rx_xfer  = rx_i && credit_o;
    assign body_bad = (data_i != rx_cnt);

    always_comb begin
        snk_next = snk_state;
        rpt_load = 1'b0;
        if (rx_xfer) begin
            case (snk_state)
                R_HDR:  snk_next = R_SIZE;
                R_SIZE: snk_next = R_TS;
                R_TS:   snk_next = R_SEQ;
                R_SEQ: begin
                    snk_next = (rx_len == TWO) ? R_HDR : R_BODY;
                    rpt_load = (rx_len == TWO);
                end
                R_BODY: begin
                    if (rx_cnt == rx_len - THREE) begin
                        snk_next = R_HDR;
                        rpt_load = 1'b1;
                    end
                end
                default: snk_next = R_HDR;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snk_state     <= R_HDR;
            rx_src        <= '0;
            rx_size       <= '0;
            rx_len        <= '0;
            rx_cnt        <= '0;
            rx_lat        <= '0;
            rx_seq        <= '0;
            rx_bad_tgt    <= 1'b0;
            rx_bad_pay    <= 1'b0;
            rpt_valid_o   <= 1'b0;
            rpt_src_o     <= '0;
            rpt_size_o    <= '0;
            rpt_seq_o     <= '0;
            rpt_latency_o <= '0;
            rpt_err_o     <= '0;
        end else begin
            snk_state <= snk_next;
            if (rx_xfer) begin
                case (snk_state)
                    R_HDR: begin
                        rx_src     <= data_i[FLIT_SIZE-1:FLIT_SIZE/2];
                        rx_bad_tgt <= (data_i[FLIT_SIZE/2-1:0] != {MY_X, MY_Y});
                        rx_bad_pay <= 1'b0;
                    end
                    R_SIZE: begin
                        rx_size <= data_i;
                        rx_len  <= (data_i < TWO) ? TWO : data_i;
                    end
                    R_TS: rx_lat <= timer - data_i[TS_WIDTH-1:0];
                    R_SEQ: begin
                        rx_seq <= data_i[SEQ_WIDTH-1:0];
                        rx_cnt <= '0;
                    end
                    R_BODY: begin
                        rx_cnt <= rx_cnt + FLIT_SIZE'(1);
                        if (body_bad) rx_bad_pay <= 1'b1;
                    end
                    default: ;
                endcase
            end
            // A load can only coincide with a handshake, never with a stalled
            // report, because credit_o blocks the final flit in that case.
            if (rpt_load) begin
                rpt_valid_o   <= 1'b1;
                rpt_src_o     <= rx_src;
                rpt_size_o    <= rx_size;
                rpt_seq_o     <= (snk_state == R_SEQ) ? data_i[SEQ_WIDTH-1:0] : rx_seq;
                rpt_latency_o <= rx_lat;
                rpt_err_o     <= {rx_bad_tgt, rx_bad_pay | ((snk_state == R_BODY) && body_bad)};
            end else if (rpt_ready_i) begin
                rpt_valid_o <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hermes_traffic_node.sv
`default_nettype none
// ============================================================================
// tb_hermes_traffic_node : directed scoreboard bench for hermes_traffic_node
// Rev 1.0
// ============================================================================
module tb_hermes_traffic_node;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [7:0]  cmd_time = '0;
    logic [7:0]  cmd_x = '0, cmd_y = '0;
    logic [31:0] cmd_size = '0;
    logic        tx, credit_i, rx, credit_o;
    logic [31:0] data_o, data_i;
    logic        rpt_valid, rpt_ready = 1'b1;
    logic [15:0] rpt_src, rpt_seq;
    logic [31:0] rpt_size;
    logic [7:0]  rpt_lat;
    logic [1:0]  rpt_err;

    logic        loop_en = 1'b0, tb_rx = 1'b0, tb_credit = 1'b1;
    logic [31:0] tb_data = '0;

    assign rx       = loop_en ? tx       : tb_rx;
    assign data_i   = loop_en ? data_o   : tb_data;
    assign credit_i = loop_en ? credit_o : tb_credit;

    hermes_traffic_node #(
        .FLIT_SIZE(32), .SRC_X(0), .SRC_Y(0), .TS_WIDTH(8), .SEQ_WIDTH(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_time_i(cmd_time),
        .cmd_tgt_x_i(cmd_x), .cmd_tgt_y_i(cmd_y), .cmd_size_i(cmd_size),
        .tx_o(tx), .data_o(data_o), .credit_i(credit_i),
        .rx_i(rx), .data_i(data_i), .credit_o(credit_o),
        .rpt_valid_o(rpt_valid), .rpt_ready_i(rpt_ready),
        .rpt_src_o(rpt_src), .rpt_size_o(rpt_size), .rpt_seq_o(rpt_seq),
        .rpt_latency_o(rpt_lat), .rpt_err_o(rpt_err)
    );

    always #5 clk = ~clk;

    // Reference timer: zero in reset, +1 per cycle, 8-bit wrap.
    logic [7:0] tmodel;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmodel <= '0;
        else        tmodel <= tmodel + 8'd1;
    end

    typedef struct packed {
        logic [15:0] src;
        logic [31:0] size;
        logic [15:0] seq;
        logic [7:0]  lat;
        logic [1:0]  err;
    } rpt_t;

    logic [31:0] exp_flit[$];
    bit          exp_ts[$];
    rpt_t        exp_rpt[$];
    logic [15:0] exp_seq = '0;
    int          checks = 0, errors = 0;
    logic [31:0] mon_exp;
    bit          mon_ts;
    rpt_t        mon_rpt;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", name, obs, expv);
        end
    endtask

    // Injected flits: TS entries must carry the timer of the cycle they move in.
    always @(negedge clk) begin
        if (rst_n && tx && credit_i) begin
            chk("flit_expected", exp_flit.size() != 0, 1);
            if (exp_flit.size() != 0) begin
                mon_exp = exp_flit.pop_front();
                mon_ts  = exp_ts.pop_front();
                if (mon_ts) mon_exp = {24'h0, tmodel};
                chk("tx_flit", data_o, mon_exp);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && rpt_valid && rpt_ready) begin
            chk("rpt_expected", exp_rpt.size() != 0, 1);
            if (exp_rpt.size() != 0) begin
                mon_rpt = exp_rpt.pop_front();
                chk("rpt_src", rpt_src, mon_rpt.src);
                chk("rpt_size", rpt_size, mon_rpt.size);
                chk("rpt_seq", rpt_seq, mon_rpt.seq);
                chk("rpt_latency", rpt_lat, mon_rpt.lat);
                chk("rpt_err", rpt_err, mon_rpt.err);
            end
        end
    end

    task automatic issue_cmd(input logic [7:0] t, input logic [7:0] x, input logic [7:0] y,
                             input logic [31:0] sz, input bit want_rpt);
        logic [31:0] n;
        n = (sz < 32'd2) ? 32'd2 : sz;
        exp_flit.push_back({16'h0, x, y});   exp_ts.push_back(1'b0);
        exp_flit.push_back(n);               exp_ts.push_back(1'b0);
        exp_flit.push_back(32'h0);           exp_ts.push_back(1'b1);
        exp_flit.push_back({16'h0, exp_seq}); exp_ts.push_back(1'b0);
        for (int k = 0; k < int'(n) - 2; k++) begin
            exp_flit.push_back(32'(k));
            exp_ts.push_back(1'b0);
        end
        if (want_rpt) exp_rpt.push_back('{16'h0, sz, exp_seq, 8'h0, 2'b00});
        exp_seq = exp_seq + 16'd1;
        @(negedge clk);
        chk("cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_time = t; cmd_x = x; cmd_y = y; cmd_size = sz;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_tx(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx) break;
        end
        chk("tx_rise", tx, 1);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_flit.size() == 0 && exp_rpt.size() == 0) break;
        end
        chk("drain", exp_flit.size() + exp_rpt.size(), 0);
        @(posedge clk); #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the flit has moved.
    task automatic send_flit(input logic [31:0] d, input bit is_ts, input logic [7:0] lat);
        tb_rx = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tb_data = is_ts ? {24'h0, 8'(tmodel - lat)} : d;
            @(negedge clk);
            if (credit_o) break;
            @(posedge clk); #1;
        end
        chk("sink_credit", credit_o, 1);
        @(posedge clk); #1;
        tb_rx = 1'b0;
    endtask

    task automatic send_pkt(input logic [15:0] src, input logic [15:0] tgt, input logic [31:0] sz,
                            input logic [7:0] lat, input logic [15:0] seq,
                            input int bad_k, input logic [31:0] bad_v);
        logic [31:0] n;
        logic [1:0]  err;
        n      = (sz < 32'd2) ? 32'd2 : sz;
        err[1] = (tgt != 16'h0);
        err[0] = (bad_k >= 0) && (bad_k < int'(n) - 2) && (bad_v != 32'(bad_k));
        exp_rpt.push_back('{src, sz, seq, lat, err});
        send_flit({src, tgt}, 1'b0, 8'h0);
        send_flit(sz, 1'b0, 8'h0);
        send_flit(32'h0, 1'b1, lat);
        send_flit({16'h0, seq}, 1'b0, 8'h0);
        for (int k = 0; k < int'(n) - 2; k++)
            send_flit((k == bad_k) ? bad_v : 32'(k), 1'b0, 8'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tx", tx, 0);
        chk("rst_data", data_o, 0);
        chk("rst_rpt_valid", rpt_valid, 0);
        chk("rst_rpt_fields", {rpt_src, rpt_size, rpt_seq, rpt_lat, rpt_err}, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_credit_o", credit_o, 1);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Future command time: header appears the cycle after the timer reaches it.
        issue_cmd(8'd50, 8'd2, 8'd1, 32'd4, 1'b0);
        wait_tx(100);
        chk("hdr_time", tmodel, 8'd51);
        wait_drain(50);

        // Loopback, size 2: one report with zero latency.
        loop_en = 1'b1;
        issue_cmd(tmodel, 8'd0, 8'd0, 32'd2, 1'b1);
        wait_drain(60);
        repeat (4) @(negedge clk);
        chk("loop_no_extra_rpt", exp_rpt.size(), 0);
        @(posedge clk); #1;
        loop_en = 1'b0;

        // Credit stalls during BODY.
        pat = 10'b11_1001_1111;
        issue_cmd(tmodel, 8'd1, 8'd2, 32'd6, 1'b0);
        wait_tx(20);
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
            tb_credit = pat[c];
            @(negedge clk);
            chk("tx_held_high", tx, 1);
            if (!pat[c]) chk("held_body1", data_o, 32'd1);
        end
        @(posedge clk); #1;
        tb_credit = 1'b1;
        @(negedge clk);
        chk("tx_after_pkt", tx, 0);
        chk("stall_all_flits", exp_flit.size(), 0);
        @(posedge clk); #1;

        // Sink error detection and clamping.
        send_pkt(16'h0102, 16'h0303, 32'd4, 8'd5, 16'h1234, 1, 32'd7);
        send_pkt(16'h0304, 16'h0000, 32'd0, 8'd3, 16'h00AA, -1, 32'd0);
        send_pkt(16'h0506, 16'h0000, 32'd5, 8'd0, 16'hBEEF, -1, 32'd0);
        wait_drain(20);

        // Report backpressure blocks the next packet.
        rpt_ready = 1'b0;
        send_pkt(16'h0708, 16'h0000, 32'd3, 8'd2, 16'h0011, -1, 32'd0);
        tb_rx = 1'b1;
        tb_data = 32'h0909_0000;
        repeat (3) begin
            @(negedge clk);
            chk("bp_credit_o", credit_o, 0);
            chk("bp_rpt_valid", rpt_valid, 1);
        end
        @(posedge clk); #1;
        rpt_ready = 1'b1;
        send_pkt(16'h0909, 16'h0000, 32'd2, 8'd1, 16'h0022, -1, 32'd0);
        wait_drain(20);

        // Command time across timer wrap, then reset in mid-BODY.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tmodel == 8'hEF) break;
        end
        chk("timer_reach", tmodel, 8'hEF);
        @(posedge clk); #1;
        issue_cmd(8'h10, 8'd1, 8'd1, 32'd6, 1'b0);
        wait_tx(100);
        chk("wrap_hdr_time", tmodel, 8'h11);
        for (int i = 0; i < 20; i++) begin
            if (tx && data_o == 32'd1) break;
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_tx", tx, 0);
        chk("midrst_data", data_o, 0);
        chk("midrst_rpt_valid", rpt_valid, 0);
        chk("midrst_rpt_fields", {rpt_src, rpt_size, rpt_seq, rpt_lat, rpt_err}, 0);
        exp_flit.delete();
        exp_ts.delete();
        exp_seq = '0;
        #14 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_no_tx", tx, 0);
        end
        @(posedge clk); #1;

        // Sequence counter restarts at zero after reset.
        loop_en = 1'b1;
        issue_cmd(tmodel, 8'd0, 8'd0, 32'd2, 1'b1);
        wait_drain(60);
        loop_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hermes_traffic_node.md
Name: hermes_traffic_node

Overview:
Synthesizable traffic generator and sink for one HermesNoC local port. It replaces file-driven bench stimulus so that emulation and FPGA runs can use it. The injector turns queued commands into Hermes packets (header, size, timestamp, sequence, payload) on the router's local input. The sink consumes packets from the router's local output, checks them, and emits one latency/integrity report per packet.

Parameters:
FLIT_SIZE, 32, flit width in bits; must be a multiple of 4 and at least 16
SRC_X, 0, X address of this node
SRC_Y, 0, Y address of this node
TS_WIDTH, 32, width of the free-running timer; TS_WIDTH <= FLIT_SIZE
SEQ_WIDTH, 16, per-node packet sequence counter width; SEQ_WIDTH <= FLIT_SIZE

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  injection command valid
cmd_ready_o  out  1  injector idle, command accepted when valid&ready
cmd_time_i  in  TS_WIDTH  earliest injection time, as a timer value
cmd_tgt_x_i  in  FLIT_SIZE/4  target X
cmd_tgt_y_i  in  FLIT_SIZE/4  target Y
cmd_size_i  in  FLIT_SIZE  flits after the size flit; values below 2 are clamped to 2
tx_o  out  1  flit valid towards router local input
data_o  out  FLIT_SIZE  flit towards router
credit_i  in  1  router can accept a flit
rx_i  in  1  flit valid from router local output
data_i  in  FLIT_SIZE  flit from router
credit_o  out  1  node can accept a flit
rpt_valid_o  out  1  report valid
rpt_ready_i  in  1  report consumed
rpt_src_o  out  FLIT_SIZE/2  source {x,y} from the header
rpt_size_o  out  FLIT_SIZE  received size field
rpt_seq_o  out  SEQ_WIDTH  received sequence number
rpt_latency_o  out  TS_WIDTH  timer at timestamp-flit receipt minus the carried timestamp, modulo 2^TS_WIDTH
rpt_err_o  out  2  bit0: payload mismatch; bit1: header target differs from SRC_X/SRC_Y

Behaviour:
- Reset (asynchronous, rst_ni=0) drives the following to zero: timer, sequence counter, tx_o, data_o, rpt_valid_o and all rpt_* fields. Both FSMs go to their first state. Reset in mid-packet abandons the packet; no further flits are sent.
- Timer: increments every cycle after reset and wraps at 2^TS_WIDTH.
- Flit transfer rule (both directions): a flit moves on a posedge where valid and credit are both 1. data_o and tx_o stay stable until that transfer.
- Injector FSM:
  - IDLE (cmd_ready_o=1): on cmd_valid_i, latch the command and go to WAIT.
  - WAIT: go to HDR once (timer - cmd_time) has MSB 0, i.e. the time has been reached or passed (wrap-safe). A command time already in the past therefore causes HDR on the next cycle.
  - HDR: data_o = {SRC_X, SRC_Y, tgt_x, tgt_y}, each FLIT_SIZE/4 bits, MSB first.
  - SIZE: data_o = clamped size N.
  - TS: data_o = timer value captured on entry to TS, zero-extended. It is held under backpressure.
  - SEQ: data_o = sequence counter, zero-extended. The counter increments when this flit transfers.
  - BODY: N-2 flits with values 0,1,2,...
  - After the last transfer, return to IDLE with tx_o=0 on the next cycle. N=2 returns to IDLE after SEQ.
  - Throughput: one flit per cycle while credit_i=1. There is no bubble between flits of a packet.
- Sink FSM: R_HDR → R_SIZE → R_TS → R_SEQ → R_BODY → R_HDR.
  - Each state advances on a transfer.
  - R_TS computes the latency.
  - R_BODY checks that flit k equals k; any mismatch sets err bit0.
  - On the final flit (or after R_SEQ when size=2), load the report registers and set rpt_valid_o on the next cycle.
  - Received size values below 2 are treated as 2.
- Report handshake: rpt_valid_o stays high until rpt_ready_i. It clears on the cycle after the handshake, unless a new report loads on that same cycle; in that case the new report wins.
- Sink backpressure: credit_o = !(rpt_valid_o && !rpt_ready_i). The sink never drops a report.
- The injector and sink are fully independent. A node may send to itself.

Test Plan:
- Reset, then command at time 50, target (2,1), size 4, SRC=(0,0), credit_i=1 → tx_o rises once timer≥50; flits are 0x00000201, 4, ts=50-or-later, 0, 0, 1.
- Loopback, tx_o/data_o wired to rx_i/data_i, command size 2, target (0,0) → exactly one report: latency 0, seq 0, err 00, size 2.
- credit_i toggles 1,0,0,1 during BODY → flit held, no duplicates or drops, payload sequence intact, tx_o never drops mid-packet.
- Injected sink stream with body flit 1 = 7 and header target (3,3) at node (0,0) → rpt_err_o = 11.
- rpt_ready_i held 0 while a second packet arrives → credit_o=0 and rx_i flits are not consumed; release rpt_ready_i → second report follows.
- Command time 0x10 issued with the timer near wrap (TS_WIDTH=8, timer 0xF0) → waits until the timer wraps to 0x10; reset asserted mid-BODY → tx_o=0 immediately, cmd_ready_o=1 after release.
